// File: rtl/quadrature_gen.sv
`default_nettype none
// ============================================================================
//  Module   : quadrature_gen
//  Purpose  : Quadrature (A/B phase) waveform generator. Each accepted step
//             command emits p_EDGES_PER_STEP Gray-code transitions on
//             o_phase_a/o_phase_b, with every level held p_HOLD clocks.
//             CW order {A,B}: 00->10->11->01->00 (A leads B); CCW reversed.
//  Ports    : CLK          - system clock, all logic on posedge
//             RST          - asynchronous active-high reset
//             i_step_valid - step command present
//             i_step_cw    - command direction (1 = CW, 0 = CCW)
//             o_step_ready - command accepted when valid && ready
//             o_phase_a    - phase A (registered)
//             o_phase_b    - phase B (registered)
//             o_busy       - high while a step is being emitted
//             ov_pos       - signed edge position (QGEN_POS_EN only)
//  Config   : `define QGEN_POS_EN adds the ov_pos position counter.
//  Revision : 1.0 - initial release
// ============================================================================
module quadrature_gen #(
  parameter int p_HOLD           = 8,
  parameter int p_EDGES_PER_STEP = 4,
  parameter int p_POS_WIDTH      = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_step_valid,
  input  logic i_step_cw,
  output logic o_step_ready,
  output logic o_phase_a,
  output logic o_phase_b,
  output logic o_busy
`ifdef QGEN_POS_EN
  ,
  output logic signed [p_POS_WIDTH-1:0] ov_pos
`endif
);

  localparam int TIMER_W = (p_HOLD > 2) ? $clog2(p_HOLD) : 1;
  localparam logic [TIMER_W-1:0] HOLD_M1  = TIMER_W'(p_HOLD - 1);
  localparam logic [1:0]         EDGES_M1 = 2'(p_EDGES_PER_STEP - 1);

  // Parameter legality: the downstream decoder's sync chain needs >= 2
  // clocks per level, and edges_left is only 2 bits wide.
  if (p_HOLD < 2) begin : g_bad_hold
    $error("quadrature_gen: p_HOLD must be >= 2");
  end
  if (p_EDGES_PER_STEP != 1 && p_EDGES_PER_STEP != 2 && p_EDGES_PER_STEP != 4) begin : g_bad_edges
    $error("quadrature_gen: p_EDGES_PER_STEP must be 1, 2 or 4");
  end
  if (p_POS_WIDTH < 2) begin : g_bad_pos
    $error("quadrature_gen: p_POS_WIDTH must be >= 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [TIMER_W-1:0]   timer;
  logic [1:0]           edges_left;
  logic                 dir_cw;
  logic                 accept;
  logic                 advance;
  logic                 step_edge;
  logic                 edge_cw;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx     = state;
    o_step_ready = 1'b0;
    o_busy       = 1'b0;
    accept       = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE: begin
        o_step_ready = 1'b1;
        if (i_step_valid) begin
          accept   = 1'b1;
          state_nx = MOVE;
        end
      end
      MOVE: begin
        o_busy = 1'b1;
        if (timer == '0) begin
          if (edges_left != 2'd0) begin
            advance = 1'b1;
          end else begin
            // Last hold cycle: a new command taken here keeps the edge
            // spacing at exactly p_HOLD clocks.
            o_step_ready = 1'b1;
            if (i_step_valid) begin
              accept = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Direction is taken live from the input only on the accepting cycle;
  // afterwards the latched copy is used so mid-step changes are ignored.
  assign step_edge = accept | advance;
  assign edge_cw   = accept ? i_step_cw : dir_cw;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer      <= '0;
      edges_left <= 2'd0;
      dir_cw     <= 1'b0;
      o_phase_a  <= 1'b0;
      o_phase_b  <= 1'b0;
    end else begin
      if (accept) begin
        dir_cw     <= i_step_cw;
        edges_left <= EDGES_M1;
        timer      <= HOLD_M1;
      end else if (advance) begin
        edges_left <= edges_left - 2'd1;
        timer      <= HOLD_M1;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      // One Gray step: CW {A,B} <- {~B, A}; CCW {A,B} <- {B, ~A}.
      if (step_edge) begin
        if (edge_cw) begin
          o_phase_a <= ~o_phase_b;
          o_phase_b <= o_phase_a;
        end else begin
          o_phase_a <= o_phase_b;
          o_phase_b <= ~o_phase_a;
        end
      end
    end
  end

`ifdef QGEN_POS_EN
  // Position tracks edges in the same cycle they appear on the phases;
  // wraps in two's complement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ov_pos <= '0;
    end else if (step_edge) begin
      if (edge_cw) begin
        ov_pos <= ov_pos + 1'b1;
      end else begin
        ov_pos <= ov_pos - 1'b1;
      end
    end
  end
`else
  // Position counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_quadrature_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quadrature_gen
//  Purpose  : Self-checking bench for quadrature_gen. A reference model
//             computes expected phases/handshake from the acceptance cycle
//             of the current command using plain arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_gen;

  localparam int HOLD  = 8;
  localparam int EDGES = 4;
  localparam int POS_W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic i_step_valid = 1'b0;
  logic i_step_cw = 1'b0;
  logic o_step_ready, o_phase_a, o_phase_b, o_busy;
`ifdef QGEN_POS_EN
  logic signed [POS_W-1:0] ov_pos;
`endif

  quadrature_gen #(
    .p_HOLD(HOLD),
    .p_EDGES_PER_STEP(EDGES),
    .p_POS_WIDTH(POS_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .i_step_valid(i_step_valid),
    .i_step_cw(i_step_cw),
    .o_step_ready(o_step_ready),
    .o_phase_a(o_phase_a),
    .o_phase_b(o_phase_b),
    .o_busy(o_busy)
`ifdef QGEN_POS_EN
    ,
    .ov_pos(ov_pos)
`endif
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int  cyc       = 0;
  int  acc_cyc   = 0;
  bit  have_acc  = 1'b0;
  bit  cmd_cw    = 1'b0;
  int  base_idx  = 0;
  int  cur_idx   = 0;
  int  acc_count = 0;
  int  last_acc  = 0;
  logic [1:0] prev_ab = 2'b00;
  int         edge_q[$];
  logic [1:0] ab_q[$];

  function automatic logic [1:0] gray(input int idx);
    logic [1:0] g;
    case (idx & 3)
      0:       g = 2'b00;
      1:       g = 2'b10;
      2:       g = 2'b11;
      default: g = 2'b01;
    endcase
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample mid-cycle, compare with the model, then drive the
  // inputs seen at the next rising edge.
  task automatic step(input bit v, input bit cw);
    int n;
    bit exp_busy, exp_ready;
`ifdef QGEN_POS_EN
    logic [POS_W-1:0] pos_obs, pos_exp;
`endif
    @(negedge CLK);
    cyc++;
    if (have_acc && cyc > acc_cyc && cyc <= acc_cyc + EDGES * HOLD) begin
      n         = (cyc - acc_cyc - 1) / HOLD + 1;
      exp_busy  = 1'b1;
      exp_ready = (cyc == acc_cyc + EDGES * HOLD);
    end else begin
      n         = have_acc ? EDGES : 0;
      exp_busy  = 1'b0;
      exp_ready = 1'b1;
    end
    cur_idx = cmd_cw ? base_idx + n : base_idx - n;

    check("phase_ab", 32'({o_phase_a, o_phase_b}), 32'(gray(cur_idx)));
    check("busy", 32'(o_busy), 32'(exp_busy));
    check("ready", 32'(o_step_ready), 32'(exp_ready));
`ifdef QGEN_POS_EN
    pos_obs = ov_pos;
    pos_exp = cur_idx[POS_W-1:0];
    check("pos", 32'(pos_obs), 32'(pos_exp));
`endif

    if ({o_phase_a, o_phase_b} != prev_ab) begin
      edge_q.push_back(cyc);
      ab_q.push_back({o_phase_a, o_phase_b});
      prev_ab = {o_phase_a, o_phase_b};
    end

    i_step_valid = v;
    i_step_cw    = cw;
    if (v && exp_ready) begin
      have_acc  = 1'b1;
      acc_cyc   = cyc;
      base_idx  = cur_idx;
      cmd_cw    = cw;
      last_acc  = cyc;
      acc_count = acc_count + 1;
    end
  endtask

  // Hold valid until the model says the command was taken (bounded).
  task automatic send(input bit cw);
    int start;
    start = acc_count;
    for (int k = 0; k < 200 && acc_count == start; k++) step(1'b1, cw);
  endtask

  task automatic wait_idle();
    repeat (EDGES * HOLD + 4) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst_ab", 32'({o_phase_a, o_phase_b}), 32'(2'b00));
    check("rst_busy", 32'(o_busy), 32'(1'b0));
    check("rst_ready", 32'(o_step_ready), 32'(1'b1));
`ifdef QGEN_POS_EN
    check("rst_pos", 32'($unsigned(ov_pos)), 32'(0));
`endif
    @(negedge CLK);
    RST = 1'b0;
    i_step_valid = 1'b0;
    cyc++;
    have_acc = 1'b0;
    base_idx = 0;
    cur_idx  = 0;
    prev_ab  = 2'b00;
  endtask

  initial begin
    logic [1:0] exp_seq[8];
    int a0;

    // Reset state
    #2;
    check("reset_ab", 32'({o_phase_a, o_phase_b}), 32'(2'b00));
    check("reset_busy", 32'(o_busy), 32'(1'b0));
    check("reset_ready", 32'(o_step_ready), 32'(1'b1));
    @(negedge CLK);
    RST = 1'b0;

    // Single CW step: edges at +1, +9, +17, +25 after acceptance
    edge_q.delete();
    ab_q.delete();
    step(1'b1, 1'b1);
    a0 = last_acc;
    repeat (39) step(1'b0, 1'b0);
    check("single_edges", 32'(edge_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < edge_q.size(); i++)
      check("single_edge_time", 32'(edge_q[i] - a0), 32'(1 + HOLD * i));

    // Three back-to-back CW commands: 12 edges, uniform spacing
    edge_q.delete();
    ab_q.delete();
    send(1'b1);
    send(1'b1);
    send(1'b1);
    wait_idle();
    check("b2b_edges", 32'(edge_q.size()), 32'(3 * EDGES));
    for (int i = 1; i < edge_q.size(); i++)
      check("b2b_spacing", 32'(edge_q[i] - edge_q[i-1]), 32'(HOLD));

    // CW then CCW: 10,11,01,00 then 01,11,10,00
    exp_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    edge_q.delete();
    ab_q.delete();
    send(1'b1);
    wait_idle();
    send(1'b0);
    wait_idle();
    check("rev_edges", 32'(ab_q.size()), 32'(8));
    for (int i = 0; i < 8 && i < ab_q.size(); i++)
      check("rev_seq", 32'(ab_q[i]), 32'(exp_seq[i]));

    // Valid held during MOVE with direction toggling mid-step
    send(1'b1);
    for (int k = 0; k < 3 * EDGES * HOLD; k++) step(1'b1, k[0]);
    wait_idle();

    // Asynchronous reset in the middle of a step (phase is 10 at that point)
    send(1'b1);
    repeat (3) step(1'b0, 1'b0);
    check("pre_rst_ab", 32'({o_phase_a, o_phase_b}), 32'(2'b10));
    do_reset();
    repeat (4) step(1'b0, 1'b0);

    // Randomized commands and directions
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 3) != 0, 1'($urandom % 2));
    end
    wait_idle();

`ifdef QGEN_POS_EN
    // Position wrap: 32 CW steps from 0 -> 0x80, then 32 CCW -> 0x00
    do_reset();
    for (int k = 0; k < 32; k++) send(1'b1);
    wait_idle();
    check("pos_wrap_up", 32'($unsigned(ov_pos)), 32'(8'h80));
    for (int k = 0; k < 32; k++) send(1'b0);
    wait_idle();
    check("pos_wrap_down", 32'($unsigned(ov_pos)), 32'(8'h00));
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
